// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses instMem combinationally and
// registers the returned instruction for decode behind a valid/ready handshake.
module fetch_unit #(
    parameter int                ADDR_W   = 5,
    parameter int                INST_W   = 13,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              halt_req,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_instr,
    output logic              if_valid,
    output logic [INST_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    input  logic              if_ready,
    output logic              running,
    output logic              pc_wrap
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] PC_MAX = '1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_if_pc;
    logic [INST_W-1:0] r_if_instr;
    logic              r_if_valid;
    logic              r_pc_wrap;

    logic              w_accept;
    logic              w_capture;
    logic              w_start_ok;
    logic              w_running;

    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from the same pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every combinational output is given a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (start)    w_state_nxt = ST_FETCH;
            ST_FETCH:  if (halt_req) w_state_nxt = ST_HALTED;
            ST_HALTED: if (start)    w_state_nxt = ST_FETCH;
            default:                 w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_running = 1'b0;
        case (r_state)
            ST_FETCH: w_running = 1'b1;
            default:  w_running = 1'b0;
        endcase
    end

    // A fetch is captured only when fetching, not redirected or halting,
    // and the pipeline register is empty or being drained this cycle.
    assign w_accept   = !r_if_valid || if_ready;
    assign w_capture  = (r_state == ST_FETCH) && !redirect_valid && !halt_req && w_accept;
    assign w_start_ok = start && (r_state != ST_FETCH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= redirect_pc;
        end else if (w_capture) begin
            r_pc <= r_pc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_valid <= 1'b0;
            r_if_instr <= '0;
            r_if_pc    <= '0;
        end else if (redirect_valid) begin
            r_if_valid <= 1'b0;
        end else if (w_capture) begin
            r_if_valid <= 1'b1;
            r_if_instr <= imem_instr;
            r_if_pc    <= r_pc;
        end else if (r_if_valid && if_ready) begin
            r_if_valid <= 1'b0;
        end
    end

    // Sticky wrap flag: set by the capture at the top address, cleared by an
    // accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc_wrap <= 1'b0;
        end else if (w_capture && (r_pc == PC_MAX)) begin
            r_pc_wrap <= 1'b1;
        end else if (w_start_ok) begin
            r_pc_wrap <= 1'b0;
        end
    end

    assign imem_addr = r_pc;
    assign if_valid  = r_if_valid;
    assign if_instr  = r_if_instr;
    assign if_pc     = r_if_pc;
    assign running   = w_running;
    assign pc_wrap   = r_pc_wrap;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// traffic, all compared every cycle against a behavioural fetch model.
module tb_fetch_unit;

    localparam int ADDR_W = 5;
    localparam int INST_W = 13;
    localparam int DEPTH  = 32;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              halt_req;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic [ADDR_W-1:0] imem_addr;
    logic [INST_W-1:0] imem_instr;
    logic              if_valid;
    logic [INST_W-1:0] if_instr;
    logic [ADDR_W-1:0] if_pc;
    logic              if_ready;
    logic              running;
    logic              pc_wrap;

    logic [INST_W-1:0] mem [DEPTH];

    int checks = 0;
    int errors = 0;

    // Behavioural model: mode 0 = idle, 1 = fetching, 2 = halted.
    int m_mode;
    int m_pc;
    int m_valid;
    int m_instr;
    int m_ipc;
    int m_wrap;

    fetch_unit #(.ADDR_W(ADDR_W), .INST_W(INST_W), .RESET_PC('0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .halt_req       (halt_req),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_ready       (if_ready),
        .running        (running),
        .pc_wrap        (pc_wrap)
    );

    assign imem_instr = mem[imem_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_pc    = 0;
        m_valid = 0;
        m_instr = 0;
        m_ipc   = 0;
        m_wrap  = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".imem_addr"}, 32'(imem_addr), 32'(m_pc));
        check({tag, ".if_valid"},  32'(if_valid),  32'(m_valid));
        check({tag, ".if_instr"},  32'(if_instr),  32'(m_instr));
        check({tag, ".if_pc"},     32'(if_pc),     32'(m_ipc));
        check({tag, ".running"},   32'(running),   32'(m_mode == 1));
        check({tag, ".pc_wrap"},   32'(pc_wrap),   32'(m_wrap));
    endtask

    // Advance one clock: the model consumes the inputs held before the edge,
    // then outputs are compared 1ns after it.
    task automatic cyc(input string tag);
        int n_mode, n_pc, n_valid, n_instr, n_ipc, n_wrap;
        n_mode = m_mode; n_pc = m_pc; n_valid = m_valid;
        n_instr = m_instr; n_ipc = m_ipc; n_wrap = m_wrap;
        if (redirect_valid) begin
            n_pc    = int'(redirect_pc);
            n_valid = 0;
        end else if (m_mode == 1 && !halt_req && (m_valid == 0 || if_ready)) begin
            n_instr = int'(mem[m_pc]);
            n_ipc   = m_pc;
            n_valid = 1;
            n_pc    = (m_pc + 1) % DEPTH;
            if (m_pc == DEPTH - 1) n_wrap = 1;
        end else if (m_valid == 1 && if_ready) begin
            n_valid = 0;
        end
        if (m_mode == 1) begin
            if (halt_req) n_mode = 2;
        end else if (start) begin
            n_mode = 1;
            n_wrap = 0;
        end
        @(posedge clk);
        #1;
        m_mode = n_mode; m_pc = n_pc; m_valid = n_valid;
        m_instr = n_instr; m_ipc = n_ipc; m_wrap = n_wrap;
        check_all(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        halt_req = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        if_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = INST_W'($urandom);
        mem[0] = 13'h0011;
        mem[1] = 13'h0022;
        mem[2] = 13'h0033;
        mem[3] = 13'h0044;
        model_reset();

        // Reset state
        #12;
        check_all("reset");
        rst_n = 1'b1;

        // Sequential fetch
        start = 1'b1; if_ready = 1'b1;
        cyc("start");
        start = 1'b0;
        cyc("seq0");
        check("seq0.instr_const", 32'(if_instr), 32'h0011);
        cyc("seq1");
        check("seq1.instr_const", 32'(if_instr), 32'h0022);
        cyc("seq2");
        check("seq2.instr_const", 32'(if_instr), 32'h0033);

        // Stall for three cycles at if_pc=2
        if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc("stall");
            check("stall.addr_const", 32'(imem_addr), 32'd3);
            check("stall.pc_const", 32'(if_pc), 32'd2);
        end
        if_ready = 1'b1;
        cyc("seq3");
        check("seq3.instr_const", 32'(if_instr), 32'h0044);

        // Redirect to 20
        redirect_valid = 1'b1; redirect_pc = 5'd20;
        cyc("redir");
        check("redir.flush", 32'(if_valid), 32'd0);
        redirect_valid = 1'b0;
        cyc("redir.first");
        check("redir.pc_const", 32'(if_pc), 32'd20);

        // Redirect during a stall also flushes
        if_ready = 1'b0;
        cyc("redir_stall.hold");
        redirect_valid = 1'b1; redirect_pc = 5'd4;
        cyc("redir_stall.flush");
        redirect_valid = 1'b0; if_ready = 1'b1;
        cyc("redir_stall.first");

        // Halt at pc=5 with decode stalled, then resume
        if_ready = 1'b0; halt_req = 1'b1;
        cyc("halt");
        halt_req = 1'b0;
        check("halt.pending_pc", 32'(if_pc), 32'd4);
        cyc("halt.hold");
        if_ready = 1'b1;
        cyc("halt.drain");
        start = 1'b1;
        cyc("resume.start");
        start = 1'b0;
        cyc("resume.first");
        check("resume.pc_const", 32'(if_pc), 32'd5);

        // Wrap-around 30, 31, 0, 1
        redirect_valid = 1'b1; redirect_pc = 5'd30;
        cyc("wrap.redir");
        redirect_valid = 1'b0;
        for (int i = 0; i < 4; i++) cyc("wrap.run");
        check("wrap.flag_const", 32'(pc_wrap), 32'd1);
        halt_req = 1'b1;
        cyc("wrap.halt");
        halt_req = 1'b0; start = 1'b1;
        cyc("wrap.restart");
        start = 1'b0;
        check("wrap.cleared", 32'(pc_wrap), 32'd0);

        // Asynchronous reset between edges at pc=9 with if_valid=1
        redirect_valid = 1'b1; redirect_pc = 5'd8;
        cyc("arst.redir");
        redirect_valid = 1'b0;
        cyc("arst.fill");
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("arst.immediate");
        #1;
        rst_n = 1'b1;
        start = 1'b1;
        cyc("arst.start");
        start = 1'b0;
        cyc("arst.first");
        check("arst.pc_const", 32'(if_pc), 32'd0);

        // Random traffic including simultaneous start/halt/redirect
        for (int i = 0; i < 600; i++) begin
            if_ready       = ($urandom_range(0, 3) != 0);
            halt_req       = ($urandom_range(0, 15) == 0);
            start          = ($urandom_range(0, 9) == 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_pc    = ADDR_W'($urandom);
            cyc("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
